// File: rtl/anffl_tex_pkg.sv
// ---------------------------------------------------------------------------
// anffl_tex_pkg
// Shared texture-format definitions for the texture address generator and
// the texel fetch unit.
//   - 5-bit format codes, laid out as {type[2:0], class[1:0]}
//   - format-class codes
//   - helpers: bytesPerTexel, isError, straddles
// ---------------------------------------------------------------------------
package anffl_tex_pkg;

    localparam logic [1:0] CLS_8BPC       = 2'b00;
    localparam logic [1:0] CLS_16BITS     = 2'b01;
    localparam logic [1:0] CLS_COMPRESSED = 2'b10;
    localparam logic [1:0] CLS_TILED      = 2'b11;

    localparam logic [4:0] FMT_RGB_24               = 5'b00000;
    localparam logic [4:0] FMT_RGB_24_TILED         = 5'b00011;
    localparam logic [4:0] FMT_RGBA_32              = 5'b00100;
    localparam logic [4:0] FMT_RGBA_32_TILED        = 5'b00111;
    localparam logic [4:0] FMT_RGB_16               = 5'b00001;
    localparam logic [4:0] FMT_RGB_16_TILED         = 5'b01011;
    localparam logic [4:0] FMT_RGBA_16              = 5'b00101;
    localparam logic [4:0] FMT_RGBA_16_TILED        = 5'b01111;
    localparam logic [4:0] FMT_RGB_15               = 5'b01001;
    localparam logic [4:0] FMT_RGBA_15_PUNCHTHROUGH = 5'b01101;
    localparam logic [4:0] FMT_R_8_TILED            = 5'b10011;
    localparam logic [4:0] FMT_R_16_TILED           = 5'b10111;
    localparam logic [4:0] FMT_RGB_ETC2             = 5'b00010;

    // Storage size of one texel; 0 marks compressed or undefined codes.
    function automatic logic [2:0] bytesPerTexel(input logic [4:0] fmt);
        logic [2:0] bpt;
        bpt = 3'd0;
        if (fmt[1:0] != CLS_COMPRESSED) begin
            case (fmt)
                FMT_RGB_24, FMT_RGB_24_TILED:         bpt = 3'd3;
                FMT_RGBA_32, FMT_RGBA_32_TILED:       bpt = 3'd4;
                FMT_RGB_16, FMT_RGB_16_TILED,
                FMT_RGBA_16, FMT_RGBA_16_TILED,
                FMT_RGB_15, FMT_RGBA_15_PUNCHTHROUGH,
                FMT_R_16_TILED:                       bpt = 3'd2;
                FMT_R_8_TILED:                        bpt = 3'd1;
                default:                              bpt = 3'd0;
            endcase
        end
        return bpt;
    endfunction

    // Unsupported format, or a texel not aligned to its own size.
    // 24-bit and 8-bit texels may start at any byte.
    function automatic logic isError(input logic [4:0] fmt, input logic [1:0] offset);
        logic [2:0] bpt;
        bpt = bytesPerTexel(fmt);
        return (bpt == 3'd0)
            || ((bpt == 3'd4) && (offset != 2'b00))
            || ((bpt == 3'd2) && offset[0]);
    endfunction

    // A 24-bit texel at byte 2 or 3 spills into the next word.
    function automatic logic straddles(input logic [4:0] fmt, input logic [1:0] offset);
        return (bytesPerTexel(fmt) == 3'd3) && offset[1];
    endfunction

endpackage

// File: rtl/anffl_tex_texel_unpack.sv
// ---------------------------------------------------------------------------
// anffl_tex_texel_unpack
// Combinational texel extraction and expansion to RGBA8888.
//   window  in  64  byte window, byte0 = bits [7:0] (word1 in the upper half)
//   offset  in   2  byte offset of the texel within the window
//   format  in   5  texture format code
//   rgba    out 32  R[31:24] G[23:16] B[15:8] A[7:0]
// Unsupported codes produce 0; the fetch unit never uses that result.
// ---------------------------------------------------------------------------
module anffl_tex_texel_unpack
    import anffl_tex_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [4:0]  format,
    output logic [31:0] rgba
);

    logic [31:0] texBytes;
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] half;
    logic        unusedWindowTop;

    // A texel never reaches beyond byte 6 of the window.
    assign unusedWindowTop = ^window[63:56];

    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

    function automatic logic [7:0] expand4(input logic [3:0] v);
        return {v, v};
    endfunction

    always_comb begin
        texBytes = window[31:0];
        case (offset)
            2'd0:    texBytes = window[31:0];
            2'd1:    texBytes = window[39:8];
            2'd2:    texBytes = window[47:16];
            default: texBytes = window[55:24];
        endcase
    end

    assign b0   = texBytes[7:0];
    assign b1   = texBytes[15:8];
    assign b2   = texBytes[23:16];
    assign b3   = texBytes[31:24];
    assign half = texBytes[15:0];

    always_comb begin
        rgba = 32'h0;
        case (format)
            FMT_RGB_24, FMT_RGB_24_TILED:
                rgba = {b0, b1, b2, 8'hFF};
            FMT_RGBA_32, FMT_RGBA_32_TILED:
                rgba = {b0, b1, b2, b3};
            FMT_RGB_16, FMT_RGB_16_TILED:
                rgba = {expand5(half[15:11]), expand6(half[10:5]), expand5(half[4:0]), 8'hFF};
            FMT_RGBA_16, FMT_RGBA_16_TILED:
                rgba = {expand4(half[15:12]), expand4(half[11:8]),
                        expand4(half[7:4]), expand4(half[3:0])};
            FMT_RGB_15:
                rgba = {expand5(half[14:10]), expand5(half[9:5]), expand5(half[4:0]), 8'hFF};
            FMT_RGBA_15_PUNCHTHROUGH:
                rgba = {expand5(half[14:10]), expand5(half[9:5]), expand5(half[4:0]),
                        (half[15] ? 8'hFF : 8'h00)};
            FMT_R_8_TILED:
                rgba = {b0, 16'h0000, 8'hFF};
            FMT_R_16_TILED:
                rgba = {half[15:8], 16'h0000, 8'hFF};
            default:
                rgba = 32'h0;
        endcase
    end

endmodule

// File: rtl/anffl_tex_texel_fetch.sv
// ---------------------------------------------------------------------------
// anffl_tex_texel_fetch
// Fetches one texel per request from texture memory and returns it as
// RGBA8888. Reads one word, or two when a 24-bit texel crosses a word
// boundary. Compressed/undefined formats and misaligned texels return
// ERR_COLOR with texErr set, without touching memory.
//   clk, rst_n                      clock, synchronous active-low reset
//   reqValid/reqReady/reqAddr/reqFormat   request from the address generator
//   memReqValid/memReqReady/memAddr       texture memory read request
//   memRspValid/memRspData                texture memory read data
//   texValid/texReady/texRgba/texErr      texel to the sampler/filter stage
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request
// RD0   | read request for the word holding the texel's first byte
// WAIT0 | waiting for the first word
// RD1   | read request for the following word (straddling texel)
// WAIT1 | waiting for the second word
// OUT   | texel presented downstream until accepted
// ---------------------------------------------------------------------------
module anffl_tex_texel_fetch
    import anffl_tex_pkg::*;
#(
    parameter logic [31:0] ERR_COLOR = 32'hFF00FFFF
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] reqAddr,
    input  logic [4:0]  reqFormat,
    output logic        memReqValid,
    input  logic        memReqReady,
    output logic [31:0] memAddr,
    input  logic        memRspValid,
    input  logic [31:0] memRspData,
    output logic        texValid,
    input  logic        texReady,
    output logic [31:0] texRgba,
    output logic        texErr
);

    typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, OUT} fetchState_e;

    fetchState_e state;
    logic [1:0]  offsetQ;
    logic [4:0]  formatQ;
    logic [31:0] word0;
    logic [63:0] window;
    logic [31:0] unpacked;

    // In WAIT1 the incoming data is the upper word of the window; in WAIT0
    // a non-straddling texel lies entirely in the incoming word.
    assign window = (state == WAIT1) ? {memRspData, word0} : {32'h0, memRspData};

    anffl_tex_texel_unpack unpack (
        .window (window),
        .offset (offsetQ),
        .format (formatQ),
        .rgba   (unpacked)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            reqReady    <= 1'b0;
            memReqValid <= 1'b0;
            memAddr     <= 32'h0;
            texValid    <= 1'b0;
            texRgba     <= 32'h0;
            texErr      <= 1'b0;
            offsetQ     <= 2'b00;
            formatQ     <= 5'b0;
            word0       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid && reqReady) begin
                        reqReady <= 1'b0;
                        offsetQ  <= reqAddr[1:0];
                        formatQ  <= reqFormat;
                        if (isError(reqFormat, reqAddr[1:0])) begin
                            texValid <= 1'b1;
                            texErr   <= 1'b1;
                            texRgba  <= ERR_COLOR;
                            state    <= OUT;
                        end else begin
                            memReqValid <= 1'b1;
                            memAddr     <= {reqAddr[31:2], 2'b00};
                            state       <= RD0;
                        end
                    end else begin
                        reqReady <= 1'b1;
                    end
                end

                RD0: begin
                    if (memReqReady) begin
                        memReqValid <= 1'b0;
                        state       <= WAIT0;
                    end
                end

                WAIT0: begin
                    if (memRspValid) begin
                        word0 <= memRspData;
                        if (straddles(formatQ, offsetQ)) begin
                            memReqValid <= 1'b1;
                            memAddr     <= memAddr + 32'd4;
                            state       <= RD1;
                        end else begin
                            texValid <= 1'b1;
                            texErr   <= 1'b0;
                            texRgba  <= unpacked;
                            state    <= OUT;
                        end
                    end
                end

                RD1: begin
                    if (memReqReady) begin
                        memReqValid <= 1'b0;
                        state       <= WAIT1;
                    end
                end

                WAIT1: begin
                    if (memRspValid) begin
                        texValid <= 1'b1;
                        texErr   <= 1'b0;
                        texRgba  <= unpacked;
                        state    <= OUT;
                    end
                end

                OUT: begin
                    if (texReady) begin
                        texValid <= 1'b0;
                        texErr   <= 1'b0;
                        reqReady <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anffl_tex_texel_fetch.sv
module tb_anffl_tex_texel_fetch;

    localparam time PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [4:0]  reqFormat;
    logic        memReqValid;
    logic        memReqReady;
    logic [31:0] memAddr;
    logic        memRspValid;
    logic [31:0] memRspData;
    logic        texValid;
    logic        texReady;
    logic [31:0] texRgba;
    logic        texErr;

    int checks = 0;
    int errors = 0;

    logic [31:0] memOverride [logic [31:0]];
    logic [31:0] readLog [$];
    int          memStall = 0;
    int          rspDelay = 0;
    int          injectCount = 0;
    logic [31:0] injectData = 32'h0;
    time         rspTime = 0;

    always #(PERIOD / 2) clk = ~clk;

    anffl_tex_texel_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqAddr     (reqAddr),
        .reqFormat   (reqFormat),
        .memReqValid (memReqValid),
        .memReqReady (memReqReady),
        .memAddr     (memAddr),
        .memRspValid (memRspValid),
        .memRspData  (memRspData),
        .texValid    (texValid),
        .texReady    (texReady),
        .texRgba     (texRgba),
        .texErr      (texErr)
    );

    // ---------------- memory contents and reference model ----------------
    function automatic logic [31:0] memData(input logic [31:0] a);
        if (memOverride.exists(a)) return memOverride[a];
        return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    function automatic int modelBpp(input logic [4:0] f);
        case (f)
            5'b00000, 5'b00011:                                      return 3;
            5'b00100, 5'b00111:                                      return 4;
            5'b00001, 5'b01011, 5'b00101, 5'b01111,
            5'b01001, 5'b01101, 5'b10111:                            return 2;
            5'b10011:                                                return 1;
            default:                                                 return 0;
        endcase
    endfunction

    function automatic logic [7:0] rep5(input int v);
        return 8'((v * 8) + (v / 4));
    endfunction
    function automatic logic [7:0] rep6(input int v);
        return 8'((v * 4) + (v / 16));
    endfunction
    function automatic logic [7:0] rep4(input int v);
        return 8'(v * 17);
    endfunction

    function automatic void modelTexel(input logic [4:0] f, input logic [31:0] addr,
                                       output logic [31:0] rgba, output logic err,
                                       output int nReads);
        int          bpp;
        int          off;
        int          hv;
        logic [31:0] base;
        logic [7:0]  b [4];
        bpp  = modelBpp(f);
        off  = int'(addr % 4);
        base = addr - 32'(off);
        err  = (bpp == 0) || (bpp == 4 && off != 0) || (bpp == 2 && (off % 2) != 0);
        rgba = 32'hFF00FFFF;
        nReads = 0;
        if (err) return;
        nReads = (off + bpp > 4) ? 2 : 1;
        for (int k = 0; k < 4; k++) begin
            int          p;
            logic [31:0] w;
            p = off + k;
            w = memData(base + 32'(4 * (p / 4)));
            b[k] = w[8 * (p % 4) +: 8];
        end
        hv = int'(b[1]) * 256 + int'(b[0]);
        case (f)
            5'b00000, 5'b00011: rgba = {b[0], b[1], b[2], 8'hFF};
            5'b00100, 5'b00111: rgba = {b[0], b[1], b[2], b[3]};
            5'b00001, 5'b01011: rgba = {rep5(hv / 2048), rep6((hv / 32) % 64), rep5(hv % 32), 8'hFF};
            5'b00101, 5'b01111: rgba = {rep4(hv / 4096), rep4((hv / 256) % 16),
                                        rep4((hv / 16) % 16), rep4(hv % 16)};
            5'b01001:           rgba = {rep5((hv / 1024) % 32), rep5((hv / 32) % 32), rep5(hv % 32), 8'hFF};
            5'b01101:           rgba = {rep5((hv / 1024) % 32), rep5((hv / 32) % 32), rep5(hv % 32),
                                        (hv >= 32768) ? 8'hFF : 8'h00};
            5'b10011:           rgba = {b[0], 16'h0000, 8'hFF};
            default:            rgba = {b[1], 16'h0000, 8'hFF};
        endcase
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        int          stallLeft;
        int          pendCnt;
        int          injSeen;
        logic        prevValid;
        logic        pend;
        logic [31:0] pendAddr;
        logic [31:0] stallAddr;
        stallLeft = 0; pendCnt = 0; injSeen = 0;
        prevValid = 1'b0; pend = 1'b0; pendAddr = 32'h0; stallAddr = 32'h0;
        memReqReady = 1'b0;
        memRspValid = 1'b0;
        memRspData  = 32'h0;
        forever begin
            @(negedge clk);
            memRspValid = 1'b0;
            if (rst_n !== 1'b1) begin
                pend = 1'b0;
            end else if (pend) begin
                if (pendCnt == 0) begin
                    memRspValid = 1'b1;
                    memRspData  = memData(pendAddr);
                    rspTime     = $time;
                    pend        = 1'b0;
                end else begin
                    pendCnt--;
                end
            end
            if (injectCount != injSeen) begin
                injSeen     = injectCount;
                memRspValid = 1'b1;
                memRspData  = injectData;
            end
            if (memReqValid === 1'b1 && prevValid !== 1'b1) begin
                stallLeft = memStall;
                stallAddr = memAddr;
            end
            if (stallLeft > 0) begin
                memReqReady = 1'b0;
                stallLeft--;
                checks++;
                if (memReqValid !== 1'b1 || memAddr !== stallAddr || reqReady !== 1'b0) begin
                    errors++;
                    $display("FAIL mem_stall: memReqValid=%b memAddr=%h reqReady=%b, required 1 %h 0",
                             memReqValid, memAddr, reqReady, stallAddr);
                end
            end else begin
                memReqReady = 1'b1;
            end
            if (memReqValid === 1'b1 && memReqReady === 1'b1 && rst_n === 1'b1) begin
                readLog.push_back(memAddr);
                pend     = 1'b1;
                pendAddr = memAddr;
                pendCnt  = rspDelay;
            end
            prevValid = memReqValid;
        end
    end

    // ---------------- one complete request ----------------
    task automatic runReq(input string name, input logic [31:0] addr, input logic [4:0] fmt,
                          input int texStall, output logic [31:0] gotRgba, output logic gotErr);
        logic [31:0] expRgba;
        logic        expErr;
        int          expReads;
        int          n;
        logic [31:0] base;
        logic [31:0] holdRgba;
        logic        holdErr;
        modelTexel(fmt, addr, expRgba, expErr, expReads);
        base = {addr[31:2], 2'b00};
        readLog.delete();
        n = 0;
        while (reqReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: reqReady=%b, required 1", name, reqReady);
        end
        reqValid  = 1'b1;
        reqAddr   = addr;
        reqFormat = fmt;
        @(negedge clk);
        reqValid  = 1'b0;
        reqAddr   = $urandom;
        reqFormat = 5'($urandom);
        if (expErr) begin
            checks++;
            if (texValid !== 1'b1 || memReqValid !== 1'b0) begin
                errors++;
                $display("FAIL %s err_latency: texValid=%b memReqValid=%b, required 1 0",
                         name, texValid, memReqValid);
            end
        end
        n = 0;
        while (texValid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (texValid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: texValid=%b, required 1 within 200 cycles", name, texValid);
        end else if (!expErr) begin
            checks++;
            if ($time != rspTime + PERIOD) begin
                errors++;
                $display("FAIL %s mem_latency: texValid at %0t, required %0t", name, $time, rspTime + PERIOD);
            end
        end
        checks++;
        if (texRgba !== expRgba) begin
            errors++;
            $display("FAIL %s rgba: got %h, required %h (addr %h fmt %b)", name, texRgba, expRgba, addr, fmt);
        end
        checks++;
        if (texErr !== expErr) begin
            errors++;
            $display("FAIL %s err: got %b, required %b (addr %h fmt %b)", name, texErr, expErr, addr, fmt);
        end
        checks++;
        if (readLog.size() != expReads) begin
            errors++;
            $display("FAIL %s read_count: got %0d, required %0d", name, readLog.size(), expReads);
        end else begin
            for (int i = 0; i < expReads; i++) begin
                checks++;
                if (readLog[i] !== base + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL %s read_addr%0d: got %h, required %h", name, i, readLog[i], base + 32'(4 * i));
                end
            end
        end
        holdRgba = texRgba;
        holdErr  = texErr;
        for (int i = 0; i < texStall; i++) begin
            @(negedge clk);
            checks++;
            if (texValid !== 1'b1 || texRgba !== holdRgba || texErr !== holdErr || reqReady !== 1'b0) begin
                errors++;
                $display("FAIL %s tex_stall: texValid=%b texRgba=%h texErr=%b reqReady=%b, required 1 %h %b 0",
                         name, texValid, texRgba, texErr, reqReady, holdRgba, holdErr);
            end
        end
        texReady = 1'b1;
        @(negedge clk);
        texReady = 1'b0;
        checks++;
        if (texValid !== 1'b0 || reqReady !== 1'b1) begin
            errors++;
            $display("FAIL %s release: texValid=%b reqReady=%b, required 0 1", name, texValid, reqReady);
        end
        gotRgba = holdRgba;
        gotErr  = holdErr;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (reqReady !== 1'b0 || memReqValid !== 1'b0 || memAddr !== 32'h0 ||
            texValid !== 1'b0 || texRgba !== 32'h0 || texErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: reqReady=%b memReqValid=%b memAddr=%h texValid=%b texRgba=%h texErr=%b, required all 0",
                     reqReady, memReqValid, memAddr, texValid, texRgba, texErr);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (reqReady !== 1'b1 || texValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: reqReady=%b texValid=%b, required 1 0", reqReady, texValid);
        end
    endtask

    task automatic test_straddle();
        logic [31:0] r; logic e;
        memOverride[32'h10000000] = 32'h33221100;
        memOverride[32'h10000004] = 32'h77665544;
        runReq("rgb24_straddle", 32'h10000002, 5'b00000, 0, r, e);
        checks++;
        if (r !== 32'h223344FF || e !== 1'b0) begin
            errors++;
            $display("FAIL rgb24_straddle_const: got %h/%b, required 223344FF/0", r, e);
        end
        runReq("rgb24_wrap", 32'hFFFFFFFE, 5'b00011, 0, r, e);
    endtask

    task automatic test_formats();
        logic [31:0] r; logic e;
        memOverride[32'h00002000] = 32'hF8000000;
        runReq("rgb16_upper", 32'h00002002, 5'b00001, 0, r, e);
        checks++;
        if (r !== 32'hFF0000FF) begin
            errors++;
            $display("FAIL rgb16_upper_const: got %h, required FF0000FF", r);
        end
        memOverride[32'h00000040] = 32'h00007FFF;
        runReq("punchthrough", 32'h00000040, 5'b01101, 0, r, e);
        checks++;
        if (r !== 32'hFFFFFF00) begin
            errors++;
            $display("FAIL punchthrough_const: got %h, required FFFFFF00", r);
        end
    endtask

    task automatic test_error();
        logic [31:0] r; logic e;
        runReq("err_etc2", {$urandom, 2'b00} , 5'b00010, 1, r, e);
        checks++;
        if (r !== 32'hFF00FFFF || e !== 1'b1) begin
            errors++;
            $display("FAIL err_etc2_const: got %h/%b, required FF00FFFF/1", r, e);
        end
        runReq("err_misaligned32", 32'h00004001, 5'b00100, 0, r, e);
        checks++;
        if (r !== 32'hFF00FFFF || e !== 1'b1) begin
            errors++;
            $display("FAIL err_misaligned32_const: got %h/%b, required FF00FFFF/1", r, e);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic e;
        memStall = 3;
        rspDelay = 1;
        runReq("backpressure", 32'h00008010, 5'b00100, 5, r, e);
        runReq("backpressure_straddle", 32'h00008023, 5'b00000, 2, r, e);
        memStall = 0;
        rspDelay = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic e;
        int          n;
        rspDelay = 6;
        n = 0;
        while (reqReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        reqValid = 1'b1; reqAddr = 32'h00000100; reqFormat = 5'b00100;
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b0 || memReqValid !== 1'b0 || memAddr !== 32'h0 ||
            texValid !== 1'b0 || texRgba !== 32'h0 || texErr !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: reqReady=%b memReqValid=%b memAddr=%h texValid=%b texRgba=%h texErr=%b, required all 0",
                     reqReady, memReqValid, memAddr, texValid, texRgba, texErr);
        end
        rst_n = 1'b1;
        rspDelay = 0;
        @(negedge clk);
        injectData = 32'hDEADBEEF;
        injectCount++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (texValid !== 1'b0 || memReqValid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_orphan: texValid=%b memReqValid=%b, required 0 0", texValid, memReqValid);
            end
        end
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: reqReady=%b, required 1", reqReady);
        end
        runReq("after_reset", 32'h00000200, 5'b00100, 0, r, e);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic e;
        runReq("b2b_0", 32'h00000300, 5'b10011, 0, r, e);
        runReq("b2b_1", 32'h00000303, 5'b10011, 0, r, e);
        runReq("b2b_2", 32'h00000306, 5'b10111, 0, r, e);
    endtask

    task automatic test_random();
        logic [31:0] r; logic e;
        logic [4:0]  codes [12];
        logic [4:0]  f;
        logic [31:0] a;
        codes = '{5'b00000, 5'b00011, 5'b00100, 5'b00111, 5'b00001, 5'b01011,
                  5'b00101, 5'b01111, 5'b01001, 5'b01101, 5'b10011, 5'b10111};
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) f = 5'($urandom);
            else                            f = codes[$urandom_range(0, 11)];
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
            memStall = $urandom_range(0, 2);
            rspDelay = $urandom_range(0, 2);
            runReq("random", a, f, $urandom_range(0, 2), r, e);
        end
        memStall = 0;
        rspDelay = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        reqValid  = 1'b0;
        reqAddr   = 32'h0;
        reqFormat = 5'b0;
        texReady  = 1'b0;
        test_reset();
        test_straddle();
        test_formats();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
